// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Bit-counter width for a given operand width, clamped to the legal range.
    function automatic int cnt_width_f(input int w);
        int wc;
        wc = w;
        if (wc < WIDTH_MIN) begin
            wc = WIDTH_MIN;
        end else if (wc > WIDTH_MAX) begin
            wc = WIDTH_MAX;
        end else begin
            wc = w;
        end
        return $clog2(wc);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; the only arithmetic element of the serial adder.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walked LSB-first over WIDTH bits.
// Optional signed-overflow output is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width_f(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   sum_sh_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               cell_s_s;
    logic               cell_co_s;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_cin_r;
`endif

    fa_cell u_fa_cell (
        .x  (a_sh_r[0]),
        .y  (b_sh_r[0]),
        .ci (carry_r),
        .s  (cell_s_s),
        .co (cell_co_s)
    );

    // Sequencer: load on start, one bit per RUN cycle, publish result in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= {WIDTH{1'b0}};
            carry    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_cin_r <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= c_in;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    done     <= 1'b0;
                    sum_sh_r <= {cell_s_s, sum_sh_r[WIDTH-1:1]};
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    carry_r  <= cell_co_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
`ifdef SERIAL_ADD_OVF_EN
                        // Carry flop here is the carry into the MSB column.
                        ovf_cin_r <= carry_r;
`endif
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    sum     <= sum_sh_r;
                    carry   <= carry_r;
`ifdef SERIAL_ADD_OVF_EN
                    ovf     <= ovf_cin_r ^ carry_r;
`endif
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl; define SERIAL_ADD_OVF_EN to also check ovf.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks;
    int failures;
    int done_cnt;
    logic [W-1:0] held_sum;
    logic [W+1:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: {ovf, carry, sum} pushed when a request is driven.
    function automatic void push_exp(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        logic [W:0] full;
        logic       sovf;
        full = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
        sovf = (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]);
        exp_q.push_back({sovf, full});
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got done=1 sum=%h, required no pending result", sum);
            end else begin
                e = exp_q.pop_front();
                if (sum !== e[W-1:0] || carry !== e[W]) begin
                    failures++;
                    $display("FAIL result: got carry=%b sum=%h, required carry=%b sum=%h",
                             carry, sum, e[W], e[W-1:0]);
                end
`ifdef SERIAL_ADD_OVF_EN
                checks++;
                if (ovf !== e[W+1]) begin
                    failures++;
                    $display("FAIL ovf: got %b, required %b", ovf, e[W+1]);
                end
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        int k;
        int busy_cycles;
        @(negedge clk);
        a = va; b = vb; c_in = vc; start = 1'b1;
        push_exp(va, vb, vc);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && k < W + 6) begin
            if (busy === 1'b1) busy_cycles++;
            if (k == 4) begin
                checks++;
                if (sum !== held_sum) begin
                    failures++;
                    $display("FAIL sum_held: got %h, required %h", sum, held_sum);
                end
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", k);
        end
        checks++;
        if (k != W + 1) begin
            failures++;
            $display("FAIL latency: got %0d, required %0d", k, W + 1);
        end
        checks++;
        if (busy_cycles != W + 1) begin
            failures++;
            $display("FAIL busy_cycles: got %0d, required %0d", busy_cycles, W + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_at_done: got %b, required 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: got %b one cycle later, required 0", done);
        end
        held_sum = va + vb + {{(W-1){1'b0}}, vc};
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h carry=%b, required all 0",
                     busy, done, sum, carry);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %b, required 0", ovf);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
        end
        held_sum = 8'h00;
    endtask

    task automatic test_vectors;
        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h5A, 8'hA5, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_random;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc);
        end
    endtask

    task automatic test_ignore_restart;
        int dc0;
        dc0 = done_cnt;
        @(negedge clk);
        a = 8'h03; b = 8'h04; c_in = 1'b0; start = 1'b1;
        push_exp(8'h03, 8'h04, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * W + 6) @(negedge clk);
        checks++;
        if (done_cnt - dc0 != 1) begin
            failures++;
            $display("FAIL restart_ignored: got %0d done pulses, required 1", done_cnt - dc0);
        end
        checks++;
        if (busy !== 1'b0 || sum !== 8'h07) begin
            failures++;
            $display("FAIL restart_final: got busy=%b sum=%h, required busy=0 sum=07", busy, sum);
        end
        held_sum = 8'h07;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        int k;
        va[0] = 8'h81; vb[0] = 8'hC3;
        va[1] = 8'h12; vb[1] = 8'h34;
        va[2] = 8'hF0; vb[2] = 8'h20;
        @(negedge clk);
        a = va[0]; b = vb[0]; c_in = 1'b0; start = 1'b1;
        push_exp(va[0], vb[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_accept%0d: got busy=%b, required 1", i, busy);
            end
            if (i < 2) begin
                a = va[i+1]; b = vb[i+1];
                push_exp(va[i+1], vb[i+1], 1'b0);
            end else begin
                start = 1'b0;
            end
            k = 0;
            while (done !== 1'b1 && k < W + 6) begin
                @(negedge clk);
                k++;
            end
            checks++;
            if (k != W + 1) begin
                failures++;
                $display("FAIL b2b_latency%0d: got %0d, required %0d", i, k, W + 1);
            end
        end
        @(negedge clk);
        held_sum = va[2] + vb[2];
    endtask

    task automatic test_reset_mid_run;
        int dc0;
        @(negedge clk);
        a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
        push_exp(8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b done=%b sum=%h carry=%b, required all 0",
                     busy, done, sum, carry);
        end
        exp_q.delete();
        held_sum = 8'h00;
        dc0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        checks++;
        if (done_cnt != dc0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL no_done_after_reset: got %0d pulses busy=%b, required 0 pulses busy=0",
                     done_cnt - dc0, busy);
        end
        run_op(8'h10, 8'h20, 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        done_cnt = 0;
        held_sum = '0;
        test_reset();
        test_vectors();
        test_ignore_restart();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
